// File: rtl/mac_pkg.sv
// Shared definitions for the signed multiply-accumulate block.
package mac_pkg;

  // Default operand/result widths and the fixed pipeline depth.
  localparam int DEF_A_W = 25;
  localparam int DEF_B_W = 18;
  localparam int DEF_P_W = 48;
  localparam int LATENCY = 3;

  // Result word at default width.
  typedef logic signed [DEF_P_W-1:0] acc_t;

endpackage

// File: rtl/mac_if.sv
// Data/enable bundle of the MAC: operands and clock enable in, result and
// cascade out. PCOUT of one instance may be wired straight to PCIN of the next.
interface mac_if #(
  parameter int A_W = mac_pkg::DEF_A_W,
  parameter int B_W = mac_pkg::DEF_B_W,
  parameter int P_W = mac_pkg::DEF_P_W
);
  logic                  CE;
  logic signed [A_W-1:0] A;
  logic signed [B_W-1:0] B;
  logic signed [P_W-1:0] PCIN;
  logic signed [P_W-1:0] P;
  logic signed [P_W-1:0] PCOUT;

  modport master (output CE, output A, output B, output PCIN,
                  input  P,  input  PCOUT);
  modport slave  (input  CE, input  A, input  B, input  PCIN,
                  output P,  output PCOUT);
endinterface

// File: rtl/mac_mult.sv
// Two-stage signed multiplier: operand registers, then product register.
module mac_mult
  import mac_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W
) (
  input  logic                      CLK,
  input  logic                      SCLR,
  input  logic                      CE,
  input  logic signed [A_W-1:0]     a,
  input  logic signed [B_W-1:0]     b,
  output logic signed [A_W+B_W-1:0] prod_p1
);

  localparam int M_W = A_W + B_W;

  logic signed [A_W-1:0] a_p0;
  logic signed [B_W-1:0] b_p0;
  logic signed [M_W-1:0] a_ext;
  logic signed [M_W-1:0] b_ext;
  logic signed [M_W-1:0] prod;

  // Stage 1: capture operands.
  always_ff @(posedge CLK or posedge SCLR) begin
    if (SCLR) begin
      a_p0 <= '0;
      b_p0 <= '0;
    end else if (CE) begin
      a_p0 <= a;
      b_p0 <= b;
    end
  end

  // Both factors are sign-extended to the full product width so the
  // multiply is computed at A_W+B_W bits with correct signed results.
  assign a_ext = M_W'(a_p0);
  assign b_ext = M_W'(b_p0);
  assign prod  = a_ext * b_ext;

  // Stage 2: capture the product.
  always_ff @(posedge CLK or posedge SCLR) begin
    if (SCLR) begin
      prod_p1 <= '0;
    end else if (CE) begin
      prod_p1 <= prod;
    end
  end

endmodule

// File: rtl/mac.sv
// Signed MAC top: P = A*B + PCIN, 3 register stages, wraps modulo 2^P_W.
// Build option MAC_PCIN_EN: when defined the PCIN addend path is built;
// when undefined P = A*B and PCIN is ignored (latency unchanged).
module mac
  import mac_pkg::*;
#(
  parameter int A_W = DEF_A_W,
  parameter int B_W = DEF_B_W,
  parameter int P_W = DEF_P_W
) (
  input logic  CLK,
  input logic  SCLR,
  mac_if.slave bus
);

  localparam int M_W = A_W + B_W;

  // Product is widened with its sign before the add; the add itself wraps.
  function automatic logic signed [P_W-1:0] sext_prod(input logic signed [M_W-1:0] x);
    return P_W'(x);
  endfunction

  logic signed [M_W-1:0] prod_p1;
  logic signed [P_W-1:0] sum_p1;
  logic signed [P_W-1:0] p_p2;

  mac_mult #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_mult (
    .CLK     (CLK),
    .SCLR    (SCLR),
    .CE      (bus.CE),
    .a       (bus.A),
    .b       (bus.B),
    .prod_p1 (prod_p1)
  );

`ifdef MAC_PCIN_EN
  logic signed [P_W-1:0] pcin_p0;
  logic signed [P_W-1:0] pcin_p1;

  // Stage 1/2: delay PCIN alongside the multiplier's two stages.
  always_ff @(posedge CLK or posedge SCLR) begin
    if (SCLR) begin
      pcin_p0 <= '0;
      pcin_p1 <= '0;
    end else if (CE_en()) begin
      pcin_p0 <= bus.PCIN;
      pcin_p1 <= pcin_p0;
    end
  end

  assign sum_p1 = sext_prod(prod_p1) + pcin_p1;
`else
  logic unused_pcin;
  assign unused_pcin = ^bus.PCIN;
  assign sum_p1      = sext_prod(prod_p1);
`endif

  function automatic logic CE_en();
    return bus.CE;
  endfunction

  // Stage 3: register the sum as the result.
  always_ff @(posedge CLK or posedge SCLR) begin
    if (SCLR) begin
      p_p2 <= '0;
    end else if (bus.CE) begin
      p_p2 <= sum_p1;
    end
  end

  assign bus.P     = p_p2;
  assign bus.PCOUT = p_p2;

endmodule

// File: tb/tb_mac.sv
// Directed self-checking bench for mac. Expected values track MAC_PCIN_EN.
module tb_mac;
  import mac_pkg::*;

`ifdef MAC_PCIN_EN
  localparam bit PCIN_ON = 1'b1;
`else
  localparam bit PCIN_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic sclr;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mac_if #(.A_W(DEF_A_W), .B_W(DEF_B_W), .P_W(DEF_P_W)) bus ();

  mac #(.A_W(DEF_A_W), .B_W(DEF_B_W), .P_W(DEF_P_W)) dut (
    .CLK  (clk),
    .SCLR (sclr),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [DEF_A_W-1:0] a,
                       input logic signed [DEF_B_W-1:0] b,
                       input logic signed [DEF_P_W-1:0] c);
    bus.A    = a;
    bus.B    = b;
    bus.PCIN = c;
  endtask

  task automatic check(input string tag, input logic [DEF_P_W-1:0] obs,
                       input logic [DEF_P_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset with nonzero inputs, checked before any clock edge.
    sclr   = 1'b0;
    bus.CE = 1'b0;
    drive(25'sd5, 18'sd7, 48'sd3);
    #2 sclr = 1'b1;
    #1;
    check("rst_async_p", bus.P, 48'h0);
    check("rst_async_pcout", bus.PCOUT, 48'h0);

    // Held in reset while clocking with CE=1.
    bus.CE = 1'b1;
    tick();
    tick();
    check("rst_hold", bus.P, 48'h0);

    // Release: first result appears only after the third edge.
    sclr = 1'b0;
    tick();
    check("post_rst_e1", bus.P, 48'h0);
    tick();
    check("post_rst_e2", bus.P, 48'h0);
    tick();
    check("post_rst_e3", bus.P, PCIN_ON ? 48'd38 : 48'd35);

    // Basic MAC.
    drive(25'sd2, 18'sd3, 48'sd0);
    repeat (LATENCY) tick();
    check("basic1_p", bus.P, 48'h6);
    check("basic1_pcout", bus.PCOUT, 48'h6);
    drive(25'sd4, 18'sd5, 48'sd6);
    repeat (LATENCY) tick();
    check("basic2_p", bus.P, PCIN_ON ? 48'h1A : 48'h14);
    check("basic2_pcout", bus.PCOUT, PCIN_ON ? 48'h1A : 48'h14);

    // Signed operands.
    drive(25'h1000001, 18'sd7, 48'sd0);
    repeat (LATENCY) tick();
    check("signed_a", bus.P, 48'hFFFFF9000007);
    drive(25'sd16, 18'h20002, 48'h1A);
    repeat (LATENCY) tick();
    check("signed_b", bus.P, PCIN_ON ? 48'hFFFFFFE0003A : 48'hFFFFFFE00020);

    // Back-to-back throughput.
    drive(25'sd8, 18'sd2, 48'sd0);
    tick();
    drive(25'sd128, 18'sd32, 48'sd1);
    tick();
    drive(25'sd2048, 18'sd512, 48'sd17);
    tick();
    check("tput_1", bus.P, 48'd16);
    drive(25'sd0, 18'sd0, 48'sd0);
    tick();
    check("tput_2", bus.P, PCIN_ON ? 48'd4097 : 48'd4096);
    tick();
    check("tput_3", bus.P, PCIN_ON ? 48'd1048593 : 48'd1048576);
    tick();
    check("tput_flush", bus.P, 48'd0);

    // Same stream with one CE=0 cycle (garbage on the inputs meanwhile).
    drive(25'sd8, 18'sd2, 48'sd0);
    tick();
    drive(25'sd128, 18'sd32, 48'sd1);
    tick();
    drive(25'sd2048, 18'sd512, 48'sd17);
    tick();
    check("ce_1", bus.P, 48'd16);
    bus.CE = 1'b0;
    drive(25'sd99, 18'sd99, 48'sd99);
    tick();
    check("ce_hold", bus.P, 48'd16);
    bus.CE = 1'b1;
    drive(25'sd0, 18'sd0, 48'sd0);
    tick();
    check("ce_2", bus.P, PCIN_ON ? 48'd4097 : 48'd4096);
    tick();
    check("ce_3", bus.P, PCIN_ON ? 48'd1048593 : 48'd1048576);
    tick();
    check("ce_flush", bus.P, 48'd0);

    // Reset mid-stream with two operations in flight.
    drive(25'sd1, 18'sd5, 48'sd0);
    tick();
    drive(25'sd100, 18'sd3, 48'sd0);
    tick();
    drive(25'sd7, 18'sd9, 48'sd0);
    tick();
    check("mid_pre", bus.P, 48'd5);
    drive(25'sd0, 18'sd0, 48'sd0);
    #2 sclr = 1'b1;
    #1;
    check("mid_async", bus.P, 48'd0);
    tick();
    check("mid_hold", bus.P, 48'd0);
    sclr = 1'b0;
    tick();
    check("mid_after1", bus.P, 48'd0);
    tick();
    check("mid_after2", bus.P, 48'd0);
    tick();
    check("mid_after3", bus.PCOUT, 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
